// File: rtl/hierarchy.sv
// Hierarchical bitwise combiner.
// The two operands are registered, combined with a fixed bitwise operator, and
// the result is registered onto c. The total latency is two rising edges and a
// new operand pair is accepted every cycle. The block has no handshake: both
// inputs are sampled on every edge, and c always holds the result for the pair
// that was sampled two edges earlier.

// Input register stage: captures the operand pair on every rising edge.
module hier_in_reg #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] a_q,
  output logic [WIDTH-1:0] b_q
);

  // Operand capture; the asynchronous reset discards any in-flight pair at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      a_q <= a;
      b_q <= b;
    end
  end

endmodule

// Combinational bitwise operator.
// OP selects AND, OR, XOR or XNOR. Any OP value outside that set falls back to
// XOR. Each bit of y depends only on the same bit of the two operands.
module hier_logic #(
  parameter int WIDTH = 1,
  parameter int OP    = 2
) (
  input  logic [WIDTH-1:0] a_q,
  input  logic [WIDTH-1:0] b_q,
  output logic [WIDTH-1:0] y
);

  // Operator select; OP is fixed at elaboration, so only one branch survives.
  always_comb begin
    y = a_q ^ b_q;
    case (OP)
      0:       y = a_q & b_q;
      1:       y = a_q | b_q;
      2:       y = a_q ^ b_q;
      3:       y = ~(a_q ^ b_q);
      default: y = a_q ^ b_q;
    endcase
  end

endmodule

// Output register stage: holds the combined result.
module hier_out_reg #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] c
);

  // Result capture. The reset value is 0 for every operator, including XNOR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c <= '0;
    end else begin
      c <= y;
    end
  end

endmodule

// Top level: input stage -> operator -> output stage.
module hierarchy #(
  parameter int WIDTH = 1,
  parameter int OP    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c
);

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] y;

  hier_in_reg #(
    .WIDTH (WIDTH)
  ) u_in_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .a_q   (a_q),
    .b_q   (b_q)
  );

  hier_logic #(
    .WIDTH (WIDTH),
    .OP    (OP)
  ) u_logic (
    .a_q (a_q),
    .b_q (b_q),
    .y   (y)
  );

  hier_out_reg #(
    .WIDTH (WIDTH)
  ) u_out_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .y     (y),
    .c     (c)
  );

endmodule

// File: tb/tb_hierarchy.sv
// Bench for the hierarchy combiner.
// Four 1-bit instances (AND, OR, XOR, XNOR) and one 8-bit XOR instance all
// share the same clock and reset. Inputs change on falling edges and outputs
// are sampled on falling edges, which keeps both away from the active edge.
`timescale 1ns/100ps
module tb_hierarchy;

  logic       clk;
  logic       rst_n;
  logic       a;
  logic       b;
  logic [7:0] a8;
  logic [7:0] b8;
  logic       c_and;
  logic       c_or;
  logic       c_xor;
  logic       c_xnor;
  logic [7:0] c8;

  int checks   = 0;
  int failures = 0;

  hierarchy #(.WIDTH(1), .OP(0)) dut_and  (.clk(clk), .rst_n(rst_n), .a(a),  .b(b),  .c(c_and));
  hierarchy #(.WIDTH(1), .OP(1)) dut_or   (.clk(clk), .rst_n(rst_n), .a(a),  .b(b),  .c(c_or));
  hierarchy #(.WIDTH(1), .OP(2)) dut      (.clk(clk), .rst_n(rst_n), .a(a),  .b(b),  .c(c_xor));
  hierarchy #(.WIDTH(1), .OP(3)) dut_xnor (.clk(clk), .rst_n(rst_n), .a(a),  .b(b),  .c(c_xnor));
  hierarchy #(.WIDTH(8), .OP(2)) dut_w8   (.clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .c(c8));

  // Clock and watchdog
  initial clk = 1'b0;
  always #1 clk = ~clk;

  initial begin
    #20000;
    $display("FAIL watchdog: actual=timeout required=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic       a;
    logic       b;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       e_and;
    logic       e_or;
    logic       e_xor;
    logic       e_xnor;
    logic [7:0] e8;
  } vec_t;

  vec_t vecs[6];
  logic [7:0] exp_q[$];
  logic       exp1_q[$];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  // Advance to the falling edge that follows the next rising edge.
  task automatic next_neg();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_and"},  {7'd0, c_and},  8'd0);
    check({tag, "_or"},   {7'd0, c_or},   8'd0);
    check({tag, "_xor"},  {7'd0, c_xor},  8'd0);
    check({tag, "_xnor"}, {7'd0, c_xnor}, 8'd0);
    check({tag, "_w8"},   c8,             8'd0);
  endtask

  logic [7:0] bb_a8[8];
  logic [7:0] bb_b8[8];
  logic       bb_a[8];
  logic       bb_b[8];

  initial begin
    // Hand-computed truth table: (a,b) 00,01,10,11,10,01.
    vecs[0] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00};
    vecs[1] = '{1'b0, 1'b1, 8'hF0, 8'h0F, 1'b0, 1'b1, 1'b1, 1'b0, 8'hFF};
    vecs[2] = '{1'b1, 1'b0, 8'hAA, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 8'h55};
    vecs[3] = '{1'b1, 1'b1, 8'h3C, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00};
    vecs[4] = '{1'b1, 1'b0, 8'h81, 8'h7E, 1'b0, 1'b1, 1'b1, 1'b0, 8'hFF};
    vecs[5] = '{1'b0, 1'b1, 8'h12, 8'h34, 1'b0, 1'b1, 1'b1, 1'b0, 8'h26};

    bb_a  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    bb_b  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    bb_a8 = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
    bb_b8 = '{8'hFF, 8'h0F, 8'hF0, 8'h55, 8'h00, 8'hAB, 8'h12, 8'h80};

    // Reset held for three edges with the inputs driven high.
    rst_n = 1'b0;
    a = 1'b1; b = 1'b1; a8 = 8'hFF; b8 = 8'h0F;
    for (int i = 0; i < 3; i++) begin
      next_neg();
      check_all_zero("reset_hold");
    end

    // Release reset and let (1,0) settle, then assert reset asynchronously mid-cycle.
    a = 1'b1; b = 1'b0; a8 = 8'hA5; b8 = 8'h0F;
    rst_n = 1'b1;
    next_neg();
    check("release_edge1_xor", {7'd0, c_xor}, 8'd0);
    next_neg();
    check("release_edge2_xor", {7'd0, c_xor}, 8'd1);
    check("release_edge2_w8",  c8,            8'hAA);
    #0.4 rst_n = 1'b0;
    #0.2 check_all_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Truth-table sweep: each pair is held for 4 cycles and checked after 2 edges.
    for (int i = 0; i < 6; i++) begin
      a = vecs[i].a; b = vecs[i].b; a8 = vecs[i].a8; b8 = vecs[i].b8;
      next_neg();
      next_neg();
      check($sformatf("sweep%0d_and",  i), {7'd0, c_and},  {7'd0, vecs[i].e_and});
      check($sformatf("sweep%0d_or",   i), {7'd0, c_or},   {7'd0, vecs[i].e_or});
      check($sformatf("sweep%0d_xor",  i), {7'd0, c_xor},  {7'd0, vecs[i].e_xor});
      check($sformatf("sweep%0d_xnor", i), {7'd0, c_xnor}, {7'd0, vecs[i].e_xnor});
      check($sformatf("sweep%0d_w8",   i), c8,             vecs[i].e8);
      next_neg();
      next_neg();
    end

    // Latency: with b=0, a goes 0->1.
    a = 1'b0; b = 1'b0;
    next_neg(); next_neg();
    a = 1'b1;
    next_neg();
    check("latency_edge1", {7'd0, c_xor}, 8'd0);
    next_neg();
    check("latency_edge2", {7'd0, c_xor}, 8'd1);

    // Back-to-back: a new pair every cycle, results must follow exactly 2 cycles later.
    for (int i = 0; i < 10; i++) begin
      if (i >= 2) begin
        check($sformatf("b2b%0d_xor", i - 2), {7'd0, c_xor}, {7'd0, exp1_q.pop_front()});
        check($sformatf("b2b%0d_w8",  i - 2), c8,            exp_q.pop_front());
      end
      if (i < 8) begin
        a = bb_a[i]; b = bb_b[i]; a8 = bb_a8[i]; b8 = bb_b8[i];
        exp1_q.push_back(bb_a[i] ^ bb_b[i]);
        exp_q.push_back(bb_a8[i] ^ bb_b8[i]);
      end
      next_neg();
    end

    // Mid-stream reset: the pair (1,0) / (A5,0F) is in stage 1 when reset pulses.
    a = 1'b0; b = 1'b1; a8 = 8'h00; b8 = 8'h00;
    next_neg(); next_neg();
    check("midreset_pre_xor", {7'd0, c_xor}, 8'd1);
    a = 1'b1; b = 1'b0; a8 = 8'hA5; b8 = 8'h0F;
    @(posedge clk);
    #0.4 rst_n = 1'b0;
    #0.2 check_all_zero("midreset_now");
    a = 1'b0; b = 1'b0; a8 = 8'h00; b8 = 8'h00;
    #0.2 rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      next_neg();
      check($sformatf("midreset_after%0d_xor", i), {7'd0, c_xor}, 8'd0);
      check($sformatf("midreset_after%0d_w8",  i), c8,            8'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
